sha1_block_sequencer: RTL

Controller that turns a byte-length-tagged message word stream into the padded SHA-1 block stream.
- Forwards message words, then inserts the 0x80 terminator, zero fill and the 64-bit big-endian bit length.
- Frames the output into 512-bit blocks of 16 words each.
- Sits between the message source and the SHA-1 compression core, and tells the core where each block starts and ends.

---
 rtl/sha1_pkg.sv | 19 +
 rtl/sha1_pad_calc.sv | 27 ++
 rtl/sha1_block_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared constants for the SHA-1 padding sequencer: block geometry, pad bytes
// and the sequencer state encoding.
package sha1_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_BYTES = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t MSG    = 3'd1;
  localparam state_t TERM   = 3'd2;
  localparam state_t ZERO   = 3'd3;
  localparam state_t LEN_HI = 3'd4;
  localparam state_t LEN_LO = 3'd5;
  localparam state_t DONE   = 3'd6;

endpackage

// File: rtl/sha1_pad_calc.sv
// Combinational padding geometry for a message of len bytes: padded word
// count, whole message words, trailing byte count and the 64-bit bit length.
module sha1_pad_calc
  import sha1_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-2:0] total_words,
  output logic [LEN_W-3:0] full_words,
  output logic [1:0]       rem,
  output logic [63:0]      bitlen
);

  localparam int TW_W = LEN_W - 1;

  // One extra bit so len + 8 cannot wrap near the top of the length range;
  // the word count of the largest message still fits in TW_W bits.
  logic [LEN_W:0] len_pad;

  assign len_pad     = {1'b0, len} + (LEN_W+1)'(LEN_BYTES);
  assign total_words = TW_W'(((len_pad >> 6) + (LEN_W+1)'(1)) << 4);
  assign full_words  = len[LEN_W-1:2];
  assign rem         = len[1:0];
  assign bitlen      = {{(61-LEN_W){1'b0}}, len, 3'b000};

endmodule

// File: rtl/sha1_block_sequencer.sv
// Turns a length-tagged word stream into padded 512-bit SHA-1 blocks with
// block framing flags, behind a single registered output stage.
module sha1_block_sequencer
  import sha1_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             out_final,
  output logic             busy,
  output logic             done
);

  localparam int TW_W = LEN_W - 1;
  localparam int FW_W = LEN_W - 2;
  localparam logic [3:0] LAST_IDX = 4'(BLOCK_WORDS - 1);

  state_t          state;
  logic [TW_W-1:0] w_q;
  logic [TW_W-1:0] tw_q;
  logic [FW_W-1:0] fw_q;
  logic [1:0]      rem_q;
  logic [63:0]     bitlen_q;

  logic [TW_W-1:0] tw_c;
  logic [FW_W-1:0] fw_c;
  logic [1:0]      rem_c;
  logic [63:0]     bitlen_c;

  logic            accept_start;
  logic            can_load;
  logic            need_in;
  logic            emit;
  logic            final_held;
  logic            load;
  logic            at_len;
  logic [TW_W-1:0] w_next;
  logic [31:0]     word_c;

  function automatic logic [31:0] term_word(input logic [31:0] w, input logic [1:0] r);
    case (r)
      2'd1:    return {w[31:24], PAD_BYTE, 16'h0000};
      2'd2:    return {w[31:16], PAD_BYTE, 8'h00};
      2'd3:    return {w[31:8], PAD_BYTE};
      default: return {PAD_BYTE, 24'h000000};
    endcase
  endfunction

  sha1_pad_calc #(.LEN_W(LEN_W)) u_pad_calc (
    .len         (msg_len),
    .total_words (tw_c),
    .full_words  (fw_c),
    .rem         (rem_c),
    .bitlen      (bitlen_c)
  );

  assign accept_start = start && (state == IDLE);
  assign can_load     = !out_valid || out_ready;
  assign need_in      = (state == MSG) || ((state == TERM) && (rem_q != 2'd0));
  assign emit         = (state == MSG) || (state == TERM) || (state == ZERO) ||
                        (state == LEN_HI) || (state == LEN_LO);
  // Once the final word sits in the output register nothing more is loaded.
  assign final_held   = out_valid && out_final;
  assign load         = emit && can_load && (!need_in || in_valid) && !final_held;
  assign in_ready     = need_in && can_load;
  assign w_next       = w_q + TW_W'(1);
  assign at_len       = (w_next == tw_q - TW_W'(2));
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_comb begin
    word_c = 32'h0;
    case (state)
      MSG:     word_c = in_word;
      TERM:    word_c = term_word(in_word, rem_q);
      LEN_HI:  word_c = bitlen_q[63:32];
      LEN_LO:  word_c = bitlen_q[31:0];
      default: word_c = 32'h0;
    endcase
  end

  // Message geometry latched at start
  always_ff @(posedge clk) begin
    if (accept_start) begin
      tw_q     <= tw_c;
      fw_q     <= fw_c;
      rem_q    <= rem_c;
      bitlen_q <= bitlen_c;
    end
  end

  // Sequencer state and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      out_word  <= 32'h0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_final <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        out_final <= 1'b0;
      end
      if (load) begin
        out_word  <= word_c;
        out_valid <= 1'b1;
        out_first <= (w_q[3:0] == 4'd0);
        out_last  <= (w_q[3:0] == LAST_IDX);
        out_final <= (w_q == tw_q - TW_W'(1));
        w_q       <= w_next;
      end
      case (state)
        IDLE: begin
          if (accept_start) begin
            w_q   <= '0;
            state <= (fw_c == '0) ? TERM : MSG;
          end
        end
        MSG:    if (load && (w_next == {1'b0, fw_q})) state <= TERM;
        TERM:   if (load) state <= at_len ? LEN_HI : ZERO;
        ZERO:   if (load && at_len) state <= LEN_HI;
        LEN_HI: if (load) state <= LEN_LO;
        LEN_LO: if (out_valid && out_ready && out_final) state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
